// File: rtl/nn_inference_sequencer_if.sv
// rtl/nn_inference_sequencer_if.sv - sequencer to neuron datapath handshake and sample ROM bundle
interface nn_inference_sequencer_if #(
    parameter int ADDR_W  = 10,
    parameter int CLASS_W = 4
);
    logic [ADDR_W-1:0]  sample_addr;
    logic               dp_start;
    logic               layer_sel;
    logic               ld_hidden;
    logic               ld_output;
    logic               dp_ready;
    logic [CLASS_W-1:0] pred_class;
    logic [CLASS_W-1:0] label;

    modport master (
        output sample_addr, dp_start, layer_sel, ld_hidden, ld_output,
        input  dp_ready, pred_class, label
    );

    modport slave (
        input  sample_addr, dp_start, layer_sel, ld_hidden, ld_output,
        output dp_ready, pred_class, label
    );
endinterface

// File: rtl/nn_inference_sequencer.sv
// rtl/nn_inference_sequencer.sv - two-layer inference run sequencer with scoring, batch strobe and watchdog
module nn_inference_sequencer #(
    parameter int NUM_SAMPLES = 750,
    parameter int BATCH_SIZE  = 50,
    parameter int ADDR_W      = 10,
    parameter int CLASS_W     = 4,
    parameter int TIMEOUT     = 1023
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    nn_inference_sequencer_if.master dp,
    output logic                     busy,
    output logic                     batch_done,
    output logic                     done,
    output logic                     error,
    output logic [ADDR_W-1:0]        correct_count
);
    localparam int BCNT_W = (BATCH_SIZE > 1) ? $clog2(BATCH_SIZE) : 1;
    localparam int WD_W   = $clog2(TIMEOUT + 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_SAMPLES - 1);
    localparam logic [BCNT_W-1:0] LAST_BCNT = BCNT_W'(BATCH_SIZE - 1);
    localparam logic [WD_W-1:0]   WD_LAST   = WD_W'(TIMEOUT - 1);

    typedef enum logic [3:0] {
        IDLE, FETCH, H_START, H_WAIT, H_LOAD,
        O_START, O_WAIT, O_LOAD, CHECK, NEXT, FIN
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q;
    logic [ADDR_W-1:0]   cc_q;
    logic [BCNT_W-1:0]   bcnt_q;
    logic [WD_W-1:0]     wd_q;
    logic                err_q;
    logic                bd_q;
    logic [CLASS_W-1:0]  pred_w;
    logic [CLASS_W-1:0]  label_w;
    logic                in_wait;
    logic                wd_expired;
    logic                is_last;
    logic                launch;

    assign pred_w     = dp.pred_class;
    assign label_w    = dp.label;
    assign in_wait    = (state_q == H_WAIT) || (state_q == O_WAIT);
    assign wd_expired = in_wait && !dp.dp_ready && (wd_q == WD_LAST);
    assign is_last    = (addr_q == LAST_ADDR);
    assign launch     = start && ((state_q == IDLE) || (state_q == FIN));

    assign dp.sample_addr = addr_q;
    assign correct_count  = cc_q;

    // State register
    always_ff @(posedge clk) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    // Next-state: walk both layers per sample, bail to FIN on a hung datapath
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = FETCH;
            FETCH:   state_d = H_START;
            H_START: state_d = H_WAIT;
            H_WAIT:  if (dp.dp_ready) state_d = H_LOAD;
                     else if (wd_expired) state_d = FIN;
            H_LOAD:  state_d = O_START;
            O_START: state_d = O_WAIT;
            O_WAIT:  if (dp.dp_ready) state_d = O_LOAD;
                     else if (wd_expired) state_d = FIN;
            O_LOAD:  state_d = CHECK;
            CHECK:   state_d = is_last ? FIN : NEXT;
            NEXT:    state_d = FETCH;
            FIN:     if (start) state_d = FETCH;
            default: state_d = IDLE;
        endcase
    end

    // Run counters, scoring, batch strobe and watchdog flag
    always_ff @(posedge clk) begin
        if (!rst) begin
            addr_q <= '0;
            cc_q   <= '0;
            bcnt_q <= '0;
            wd_q   <= '0;
            err_q  <= 1'b0;
            bd_q   <= 1'b0;
        end else begin
            bd_q <= 1'b0;
            wd_q <= in_wait ? wd_q + WD_W'(1) : '0;
            if (launch) begin
                addr_q <= '0;
                cc_q   <= '0;
                bcnt_q <= '0;
                err_q  <= 1'b0;
            end
            if (wd_expired) err_q <= 1'b1;
            if (state_q == CHECK) begin
                if ((pred_w == label_w) && (cc_q != {ADDR_W{1'b1}})) cc_q <= cc_q + ADDR_W'(1);
                bcnt_q <= (bcnt_q == LAST_BCNT) ? '0 : bcnt_q + BCNT_W'(1);
                bd_q   <= (bcnt_q == LAST_BCNT) || is_last;
            end
            if (state_q == NEXT) addr_q <= addr_q + ADDR_W'(1);
        end
    end

    // Moore outputs, forced low while reset is held
    always_comb begin
        dp.dp_start  = 1'b0;
        dp.layer_sel = 1'b0;
        dp.ld_hidden = 1'b0;
        dp.ld_output = 1'b0;
        busy         = 1'b0;
        batch_done   = 1'b0;
        done         = 1'b0;
        error        = 1'b0;
        if (rst) begin
            dp.dp_start  = (state_q == H_START) || (state_q == O_START);
            dp.layer_sel = (state_q == H_START) || (state_q == H_WAIT) || (state_q == H_LOAD);
            dp.ld_hidden = (state_q == H_LOAD);
            dp.ld_output = (state_q == O_LOAD);
            busy         = (state_q != IDLE) && (state_q != FIN);
            batch_done   = bd_q;
            done         = (state_q == FIN);
            error        = err_q;
        end
    end
endmodule

// File: tb/tb_nn_inference_sequencer.sv
// tb/tb_nn_inference_sequencer.sv - directed self-checking bench for nn_inference_sequencer
module tb_nn_inference_sequencer;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic start_a, start_b, start_c;
    logic busy_a, bd_a, done_a, err_a;
    logic busy_b, bd_b, done_b, err_b;
    logic busy_c, bd_c, done_c, err_c;
    logic [9:0] cc_a, cc_b, cc_c;

    nn_inference_sequencer_if #(.ADDR_W(10), .CLASS_W(4)) if_a ();
    nn_inference_sequencer_if #(.ADDR_W(10), .CLASS_W(4)) if_b ();
    nn_inference_sequencer_if #(.ADDR_W(10), .CLASS_W(4)) if_c ();

    nn_inference_sequencer #(.NUM_SAMPLES(1), .BATCH_SIZE(50), .ADDR_W(10), .CLASS_W(4), .TIMEOUT(1023)) u_a (
        .clk(clk), .rst(rst), .start(start_a), .dp(if_a),
        .busy(busy_a), .batch_done(bd_a), .done(done_a), .error(err_a), .correct_count(cc_a));
    nn_inference_sequencer #(.NUM_SAMPLES(5), .BATCH_SIZE(2), .ADDR_W(10), .CLASS_W(4), .TIMEOUT(32)) u_b (
        .clk(clk), .rst(rst), .start(start_b), .dp(if_b),
        .busy(busy_b), .batch_done(bd_b), .done(done_b), .error(err_b), .correct_count(cc_b));
    nn_inference_sequencer #(.NUM_SAMPLES(3), .BATCH_SIZE(50), .ADDR_W(10), .CLASS_W(4), .TIMEOUT(8)) u_c (
        .clk(clk), .rst(rst), .start(start_c), .dp(if_c),
        .busy(busy_c), .batch_done(bd_c), .done(done_c), .error(err_c), .correct_count(cc_c));

    // {dp_start, layer_sel, ld_hidden, ld_output, busy, batch_done, done, error}
    logic [7:0] st_a, st_b, st_c;
    assign st_a = {if_a.dp_start, if_a.layer_sel, if_a.ld_hidden, if_a.ld_output, busy_a, bd_a, done_a, err_a};
    assign st_b = {if_b.dp_start, if_b.layer_sel, if_b.ld_hidden, if_b.ld_output, busy_b, bd_b, done_b, err_b};
    assign st_c = {if_c.dp_start, if_c.layer_sel, if_c.ld_hidden, if_c.ld_output, busy_c, bd_c, done_c, err_c};

    logic mis_b, spur_b;
    int   dly_a, dly_b;
    int   cnt_a = 0, cnt_b = 0;
    logic rdy_a = 1'b0, rdy_b = 1'b0;

    assign if_a.dp_ready   = rdy_a;
    assign if_a.pred_class = 4'd3;
    assign if_a.label      = 4'd3;
    assign if_b.dp_ready   = rdy_b;
    assign if_b.pred_class = 4'd3;
    assign if_b.label      = (mis_b && (if_b.sample_addr == 10'd1 || if_b.sample_addr == 10'd4)) ? 4'd5 : 4'd3;
    assign if_c.dp_ready   = 1'b0;
    assign if_c.pred_class = 4'd3;
    assign if_c.label      = 4'd3;

    // Datapath model for u_a: ready pulse dly_a cycles after each start
    always @(negedge clk) begin
        rdy_a = 1'b0;
        if (cnt_a == 1) rdy_a = 1'b1;
        if (cnt_a != 0) cnt_a--;
        if (if_a.dp_start) cnt_a = dly_a;
    end

    // Datapath model for u_b, with an optional stray ready during the output-layer start
    always @(negedge clk) begin
        rdy_b = 1'b0;
        if (cnt_b == 1) rdy_b = 1'b1;
        if (cnt_b != 0) cnt_b--;
        if (if_b.dp_start) cnt_b = dly_b;
        if (spur_b && if_b.dp_start && !if_b.layer_sel) rdy_b = 1'b1;
    end

    int n_ldh_b = 0, n_ldo_b = 0, n_ds_b = 0, n_bd_b = 0;
    logic [9:0] log_ldh [64];
    logic [9:0] log_bd  [64];

    // Strobe monitor for u_b
    always @(negedge clk) begin
        if (if_b.ld_hidden) begin log_ldh[n_ldh_b % 64] = if_b.sample_addr; n_ldh_b++; end
        if (if_b.ld_output) n_ldo_b++;
        if (if_b.dp_start)  n_ds_b++;
        if (bd_b) begin log_bd[n_bd_b % 64] = if_b.sample_addr; n_bd_b++; end
    end

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_done_b(input int k0, input int budget, output int k);
        k = k0;
        while (!done_b && k < budget) begin
            @(negedge clk);
            k++;
        end
    endtask

    logic [7:0] exp2 [10] = '{8'h08, 8'hC8, 8'h48, 8'h68, 8'h88, 8'h08, 8'h18, 8'h08, 8'h06, 8'h02};
    int kd, h0, o0, d0, b0;

    initial begin
        rst = 1'b0; start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
        mis_b = 1'b0; spur_b = 1'b0; dly_a = 1; dly_b = 1;

        // reset then idle
        repeat (3) begin
            @(negedge clk);
            chk("rst_a", st_a, 0); chk("rst_b", st_b, 0); chk("rst_c", st_c, 0);
        end
        chk("rst_addr", if_a.sample_addr, 0);
        chk("rst_cc", cc_b, 0);
        rst = 1'b1;
        repeat (10) @(negedge clk);
        chk("idle_a", st_a, 0);
        chk("idle_b", st_b, 0);
        chk("idle_addr", if_b.sample_addr, 0);

        // single sample, cycle-exact strobes
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            chk($sformatf("t2_cyc%0d", k), st_a, exp2[k-1]);
            @(negedge clk);
        end
        chk("t2_cc", cc_a, 1);
        chk("t2_addr", if_a.sample_addr, 0);

        // batches with two mismatching labels
        mis_b = 1'b1;
        h0 = n_ldh_b; b0 = n_bd_b;
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        wait_done_b(1, 200, kd);
        chk("t3_done_cyc", kd, 45);
        repeat (2) @(negedge clk);
        chk("t3_cc", cc_b, 3);
        chk("t3_st", st_b, 8'h02);
        chk("t3_addr", if_b.sample_addr, 4);
        chk("t3_nsamp", n_ldh_b - h0, 5);
        for (int i = 0; i < 5; i++) chk($sformatf("t3_seq%0d", i), log_ldh[(h0 + i) % 64], i);
        chk("t3_nbatch", n_bd_b - b0, 3);
        chk("t3_bd0", log_bd[b0 % 64], 1);
        chk("t3_bd1", log_bd[(b0 + 1) % 64], 3);
        chk("t3_bd2", log_bd[(b0 + 2) % 64], 4);

        // slow datapath with a stray ready in O_START
        mis_b = 1'b0; dly_b = 20; spur_b = 1'b1;
        h0 = n_ldh_b; o0 = n_ldo_b; d0 = n_ds_b; b0 = n_bd_b;
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        repeat (11) @(negedge clk);
        chk("t4_hold_st", st_b, 8'h48);
        chk("t4_hold_addr", if_b.sample_addr, 0);
        wait_done_b(12, 400, kd);
        chk("t4_done_cyc", kd, 235);
        spur_b = 1'b0;
        repeat (2) @(negedge clk);
        chk("t4_ldh", n_ldh_b - h0, 5);
        chk("t4_ldo", n_ldo_b - o0, 5);
        chk("t4_dps", n_ds_b - d0, 10);
        chk("t4_nbatch", n_bd_b - b0, 3);
        chk("t4_cc", cc_b, 5);
        chk("t4_err", err_b, 0);

        // watchdog: H_WAIT entered at cycle 3, expires 8 cycles later
        start_c = 1'b1;
        @(negedge clk);
        start_c = 1'b0;
        repeat (9) @(negedge clk);
        chk("t5_pre_st", st_c, 8'h48);
        @(negedge clk);
        chk("t5_to_st", st_c, 8'h03);
        chk("t5_addr", if_c.sample_addr, 0);
        chk("t5_cc", cc_c, 0);
        @(negedge clk);
        chk("t5_hold_st", st_c, 8'h03);
        start_c = 1'b1;
        @(negedge clk);
        start_c = 1'b0;
        chk("t5_restart_st", st_c, 8'h08);

        // reset in O_WAIT of sample 2
        dly_b = 1;
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        repeat (23) @(negedge clk);
        chk("t6_owait_st", st_b, 8'h08);
        chk("t6_owait_addr", if_b.sample_addr, 2);
        rst = 1'b0;
        o0 = n_ldo_b;
        @(negedge clk);
        chk("t6_rst_st", st_b, 0);
        chk("t6_rst_addr", if_b.sample_addr, 0);
        chk("t6_rst_cc", cc_b, 0);
        rst = 1'b1;
        repeat (5) @(negedge clk);
        chk("t6_quiet_st", st_b, 0);
        chk("t6_quiet_ldo", n_ldo_b - o0, 0);

        // start pulsed while busy is ignored
        h0 = n_ldh_b;
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        repeat (11) @(negedge clk);
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        wait_done_b(13, 200, kd);
        chk("t6_done_cyc", kd, 45);
        repeat (2) @(negedge clk);
        chk("t6_cc", cc_b, 5);
        for (int i = 0; i < 5; i++) chk($sformatf("t6_seq%0d", i), log_ldh[(h0 + i) % 64], i);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
